// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the instruction/data memory arbiter.
//   owner_e      - which requester a pending read belongs to
//   W_DEF/AW_DEF - default data and address widths
//   STARVE_CNT_W - width of the instruction-fetch starvation counter
package mem_arb_pkg;

   localparam int W_DEF        = 32;
   localparam int AW_DEF       = 8;
   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'b00,
      OWNER_IF   = 2'b01,
      OWNER_DM   = 2'b10
   } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of consecutive cycles in which the
// instruction-fetch request was denied.
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   i_inc            - IF requested and was not granted this cycle
//   i_clr            - IF granted or not requesting this cycle
//   o_at_limit       - count has reached LIMIT; IF takes priority
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q < LIMIT_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_at_limit = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous-read memory between the
// instruction-fetch (IF) and data-memory (DM) ports of the core.
//   i_clk, i_reset_n                   - clock, asynchronous active-low reset
//   i_if_req/i_if_addr                 - instruction read request
//   o_if_gnt/o_if_rvalid/o_if_rdata    - IF grant and read return
//   i_dm_req/i_dm_we/i_dm_addr/i_dm_wdata - data access request
//   o_dm_gnt/o_dm_rvalid/o_dm_rdata    - DM grant and read return
//   o_mem_addr/o_mem_wdata/o_mem_read/o_mem_write - memory command
//   i_mem_rdata                        - memory data, valid the cycle after a read
// DM wins by default; IF wins once it has been denied STARVE_LIMIT cycles in a row.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int W            = W_DEF,
   parameter int AW           = AW_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_gnt,
   output logic          o_if_rvalid,
   output logic [W-1:0]  o_if_rdata,
   input  logic          i_dm_req,
   input  logic          i_dm_we,
   input  logic [AW-1:0] i_dm_addr,
   input  logic [W-1:0]  i_dm_wdata,
   output logic          o_dm_gnt,
   output logic          o_dm_rvalid,
   output logic [W-1:0]  o_dm_rdata,
   output logic [AW-1:0] o_mem_addr,
   output logic [W-1:0]  o_mem_wdata,
   output logic          o_mem_read,
   output logic          o_mem_write,
   input  logic [W-1:0]  i_mem_rdata
);

   logic   at_limit;
   logic   if_gnt;
   logic   dm_gnt;
   logic   starve_inc;
   owner_e owner_q;
   owner_e owner_d;
   logic [W-1:0] if_rdata_q;
   logic [W-1:0] dm_rdata_q;

   // Nothing is issued while reset is asserted, even if requests are high.
   assign if_gnt   = i_reset_n & i_if_req & (~i_dm_req | at_limit);
   assign dm_gnt   = i_reset_n & i_dm_req & ~if_gnt;
   assign o_if_gnt = if_gnt;
   assign o_dm_gnt = dm_gnt;

   assign starve_inc = i_if_req & ~if_gnt;

   mem_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_inc      (starve_inc),
      .i_clr      (~starve_inc),
      .o_at_limit (at_limit)
   );

   always_comb begin
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
      owner_d     = OWNER_NONE;
      if (if_gnt) begin
         o_mem_addr = i_if_addr;
         o_mem_read = 1'b1;
         owner_d    = OWNER_IF;
      end else if (dm_gnt) begin
         o_mem_addr  = i_dm_addr;
         o_mem_wdata = i_dm_wdata;
         o_mem_read  = ~i_dm_we;
         o_mem_write = i_dm_we;
         owner_d     = i_dm_we ? OWNER_NONE : OWNER_DM;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         owner_q    <= OWNER_NONE;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         owner_q <= owner_d;
         if (owner_q == OWNER_IF) begin
            if_rdata_q <= i_mem_rdata;
         end
         if (owner_q == OWNER_DM) begin
            dm_rdata_q <= i_mem_rdata;
         end
      end
   end

   // In the return cycle the memory word is forwarded directly so latency stays
   // one cycle; the register then holds it until the next read for that port.
   assign o_if_rvalid = (owner_q == OWNER_IF);
   assign o_dm_rvalid = (owner_q == OWNER_DM);
   assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_rdata_q;
   assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [7:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;
   logic [31:0] if_q[$];
   logic [31:0] dm_q[$];

   mem_arbiter dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_gnt    (if_gnt),
      .o_if_rvalid (if_rvalid),
      .o_if_rdata  (if_rdata),
      .i_dm_req    (dm_req),
      .i_dm_we     (dm_we),
      .i_dm_addr   (dm_addr),
      .i_dm_wdata  (dm_wdata),
      .o_dm_gnt    (dm_gnt),
      .o_dm_rvalid (dm_rvalid),
      .o_dm_rdata  (dm_rdata),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_read  (mem_read),
      .o_mem_write (mem_write),
      .i_mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expected word.
   always @(negedge clk) begin
      if (if_rvalid === 1'b1) begin
         if (if_q.size() == 0) check("if_unexpected_rvalid", 32'd1, 32'd0);
         else check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_rvalid === 1'b1) begin
         if (dm_q.size() == 0) check("dm_unexpected_rvalid", 32'd1, 32'd0);
         else check("dm_rdata", dm_rdata, dm_q.pop_front());
      end
   end

   task automatic drive(input logic ir, input logic [7:0] ia, input logic dr,
                        input logic dw, input logic [7:0] da, input logic [31:0] dd);
      @(posedge clk);
      #1;
      if_req   = ir;
      if_addr  = ia;
      dm_req   = dr;
      dm_we    = dw;
      dm_addr  = da;
      dm_wdata = dd;
   endtask

   task automatic expect_cmd(input string name, input logic eig, input logic edg,
                             input logic erd, input logic ewr, input logic [7:0] ea);
      @(negedge clk);
      check({name, "_if_gnt"}, {31'd0, if_gnt}, {31'd0, eig});
      check({name, "_dm_gnt"}, {31'd0, dm_gnt}, {31'd0, edg});
      check({name, "_read"},   {31'd0, mem_read}, {31'd0, erd});
      check({name, "_write"},  {31'd0, mem_write}, {31'd0, ewr});
      check({name, "_addr"},   {24'd0, mem_addr}, {24'd0, ea});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'h00500093;
      mem[8'h30] = 32'h12345678;
      mem_rdata = 32'h0;
      rst_n    = 1'b0;
      if_req   = 1'b1;
      if_addr  = 8'h10;
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = 8'h30;
      dm_wdata = 32'h0;

      // Reset held with both requests high
      repeat (3) @(posedge clk);
      expect_cmd("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      check("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);

      // Release with requests pending: DM wins immediately
      drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 32'h0);
      rst_n = 1'b1;
      expect_cmd("rel_dm", 1'b0, 1'b1, 1'b1, 1'b0, 8'h30);
      dm_q.push_back(32'h12345678);

      // IF only
      drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
      expect_cmd("if_only", 1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
      if_q.push_back(32'h00500093);

      // DM write and IF read to the same address in the same cycle
      drive(1'b1, 8'h20, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF);
      expect_cmd("wr_first", 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
      check("wr_first_wdata", mem_wdata, 32'hDEADBEEF);
      drive(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0);
      expect_cmd("if_after_wr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
      if_q.push_back(32'hDEADBEEF);

      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      expect_cmd("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("idle_wdata", mem_wdata, 32'd0);

      // Starvation: DM x4, IF on the 5th, DM again on the 6th
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 32'h0);
         if (i == 4) begin
            expect_cmd("starve_if", 1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
            if_q.push_back(32'h00500093);
         end else begin
            expect_cmd("starve_dm", 1'b0, 1'b1, 1'b1, 1'b0, 8'h30);
            dm_q.push_back(32'h12345678);
         end
      end

      // Flush: IF denied twice then dropped; counter must restart from 0
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      expect_cmd("pre_flush_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 8'h10, 1'b1, 1'b1, 8'h40, 32'hCAFE0001);
         expect_cmd("flush_dm", 1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 32'hCAFE0001);
      expect_cmd("flush_drop", 1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h40, 1'b1, 1'b1, 8'h44, 32'h0BADF00D);
         if (i == 4) begin
            expect_cmd("post_flush_if", 1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
            if_q.push_back(32'hCAFE0001);
         end else begin
            expect_cmd("post_flush_dm", 1'b0, 1'b1, 1'b0, 1'b1, 8'h44);
         end
      end

      // Async reset between a DM read grant and its return edge
      drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 32'h0);
      expect_cmd("rr_gnt", 1'b0, 1'b1, 1'b1, 1'b0, 8'h30);
      #2;
      rst_n = 1'b0;
      #1;
      check("rr_async_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      check("rr_async_dm_rdata", dm_rdata, 32'd0);
      check("rr_async_if_rdata", if_rdata, 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      check("rr_held_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      check("rr_held_dm_rdata", dm_rdata, 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rr_post_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);

      check("if_q_empty", if_q.size(), 32'd0);
      check("dm_q_empty", dm_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
